// File: rtl/l4_fc_sched.sv
// Layer-4 FC sequencer: feeds N_IN operands, captures 4 result groups, drains them downstream.
// Optional watchdog on the ready wait is enabled by defining L4_SCHED_WDOG_EN.
module l4_fc_sched #(
  parameter int unsigned N_IN   = 100,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned DW     = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  output logic                 src_rd,
  output logic [6:0]           src_addr,
  input  logic signed [DW-1:0] src_data,
  output logic                 l4_strt,
  output logic signed [DW-1:0] l4_din,
  input  logic                 l4_rdy,
  input  logic [16*DW-1:0]     l4_dout,
  output logic                 l4_tx_done,
  output logic                 out_valid,
  output logic [1:0]           out_grp,
  output logic [16*DW-1:0]     out_data,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 frame_done
`ifdef L4_SCHED_WDOG_EN
  ,
  output logic                 wdog_err
`endif
);

  localparam int unsigned IW  = $clog2(N_IN);
  localparam int unsigned DLW = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

  typedef enum logic [3:0] {
    StIdle, StPre, StLoad, StStrt, StAcc, StWaitRdy, StDly, StCap, StClr, StDrain
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            ph_q;      // ACC phase, reused as CAP group index
  logic [IW-1:0]         idx_q;
  logic [DLW-1:0]        dly_q;
  logic [1:0]            grp_q;
  logic [6:0]            addr_q;
  logic signed [DW-1:0]  din_q;
  logic [16*DW-1:0]      stage_q [4];
  logic                  done_q;
  logic                  last_in, fetch, xfer, start, timeout, abort;

  assign start   = (state_q == StIdle) && go;
  assign last_in = (idx_q == IW'(N_IN - 1));
  assign fetch   = (state_q == StAcc) && (ph_q == 2'd2) && !last_in;
  assign xfer    = (state_q == StDrain) && out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (go) state_d = StPre;
      StPre:     state_d = StLoad;
      StLoad:    state_d = StStrt;
      StStrt:    state_d = StAcc;
      StAcc:     if (ph_q == 2'd3) state_d = last_in ? StWaitRdy : StStrt;
      StWaitRdy: begin
        if (l4_rdy)       state_d = (RD_LAT > 1) ? StDly : StCap;
        else if (timeout) state_d = StClr;
      end
      StDly:     if (dly_q == DLW'(RD_LAT - 2)) state_d = StCap;
      StCap:     if (ph_q == 2'd3) state_d = StClr;
      StClr:     state_d = abort ? StIdle : StDrain;
      StDrain:   if (out_ready && (grp_q == 2'd3)) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ph_q    <= '0;
      idx_q   <= '0;
      dly_q   <= '0;
      grp_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= xfer && (grp_q == 2'd3);
      if (start) begin
        ph_q   <= '0;
        idx_q  <= '0;
        addr_q <= '0;
      end else begin
        if ((state_q == StAcc) || (state_q == StCap)) ph_q <= ph_q + 2'd1;
        if ((state_q == StAcc) && (ph_q == 2'd3) && !last_in) idx_q <= idx_q + 1'b1;
        // Address is set one phase early so it is valid alongside the phase-2 strobe
        if ((state_q == StAcc) && (ph_q == 2'd1) && !last_in) addr_q <= 7'(idx_q + 1'b1);
      end
      dly_q <= (state_q == StDly) ? dly_q + 1'b1 : '0;
      if ((state_q == StLoad) || ((state_q == StAcc) && (ph_q == 2'd3) && !last_in)) begin
        din_q <= src_data;
      end
      if (xfer) grp_q <= grp_q + 2'd1;
    end
  end

  // Staging contents are don't-care after reset, so they carry no reset
  always_ff @(posedge clk) begin
    if (state_q == StCap) stage_q[ph_q] <= l4_dout;
  end

`ifdef L4_SCHED_WDOG_EN
  logic [9:0] wd_q;
  logic       abort_q, wdog_err_q;

  assign timeout  = (state_q == StWaitRdy) && !l4_rdy && (wd_q == 10'd1022);
  assign abort    = abort_q;
  assign wdog_err = wdog_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q       <= '0;
      abort_q    <= 1'b0;
      wdog_err_q <= 1'b0;
    end else begin
      wd_q <= (state_q == StWaitRdy) ? wd_q + 10'd1 : '0;
      if (timeout) begin
        abort_q    <= 1'b1;
        wdog_err_q <= 1'b1;
      end else if (state_q == StClr) begin
        abort_q    <= 1'b0;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign abort   = 1'b0;
`endif

  assign src_rd     = (state_q == StPre) || fetch;
  assign src_addr   = addr_q;
  assign l4_strt    = (state_q == StStrt);
  assign l4_din     = din_q;
  assign l4_tx_done = (state_q == StClr);
  assign out_valid  = (state_q == StDrain);
  assign out_grp    = grp_q;
  assign out_data   = out_valid ? stage_q[grp_q] : '0;
  assign busy       = (state_q != StIdle);
  assign frame_done = done_q;

endmodule
